// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic {ARB_CORE, ARB_HOST} arb_state_t;
   function automatic int cnt_width(input int max_wait);
      return $clog2(max_wait + 1);
   endfunction
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed core-priority arbiter for dat_mem with a host starvation guard.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,
   input  logic          core_halt,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam int CW = cnt_width(MAX_WAIT);
   localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);
   arb_state_t r_state;
   logic [CW-1:0] r_wait_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic w_host_gnt;
   logic w_core_gnt;
   // Outputs are gated by reset so a reset mid-cycle kills any access at once.
   always_comb begin
      w_host_gnt = host_req && (!core_req || r_state == ARB_HOST || core_halt);
      w_core_gnt = core_req && !w_host_gnt;
      w_cnt_inc  = r_wait_cnt + CW'(1);
      mem_addr   = w_host_gnt ? host_addr : core_addr;
      mem_wdata  = w_host_gnt ? host_wdata : core_wdata;
      mem_we     = reset && (w_host_gnt ? host_we : (w_core_gnt && core_we));
      host_ack   = reset && w_host_gnt;
      core_stall = reset && core_req && w_host_gnt;
      host_rdata = mem_rdata;
      core_rdata = mem_rdata;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ARB_CORE;
         r_wait_cnt <= '0;
      end else if (w_host_gnt) begin
         r_state    <= ARB_CORE;
         r_wait_cnt <= '0;
      end else if (host_req) begin
         if (r_wait_cnt != MAXC) r_wait_cnt <= w_cnt_inc;
         if (w_cnt_inc == MAXC) r_state <= ARB_HOST;
      end else begin
         r_wait_cnt <= '0;
      end
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the processor core's load/store path and a host port used to preload operands before a run and read results after `done`. It sits between the control decoder's memory signals (`mem_addr`, `mem_in`, `MemWrite`, `mem_out`) and `dat_mem`. The core has fixed priority, and a starvation counter guarantees the host a slot. When the host wins a conflict, the core is stalled for one cycle through a stall line that gates the PC and register-file write.

## Interface
Parameters:
- `AW`, 8: memory address width
- `DW`, 8: memory data width
- `MAX_WAIT`, 4: conflict cycles a pending host request may lose before it gets priority; legal range ≥ 1

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core performs a memory access this cycle (load or store)
- `core_we`  in  1  core access is a store
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core store data
- `core_rdata`  out  DW  load data to the core; equals `mem_rdata`
- `core_stall`  out  1  core access not serviced this cycle; hold PC and suppress RegWrite
- `core_halt`  in  1  core finished (`done`); host always wins while high
- `host_req`  in  1  host request; held until `host_ack`
- `host_we`  in  1  host access is a write
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_ack`  out  1  host access performed this cycle
- `host_rdata`  out  DW  host read data; valid when `host_ack` is 1
- `mem_we`  out  1  write enable to `dat_mem`
- `mem_addr`  out  AW  address to `dat_mem`
- `mem_wdata`  out  DW  write data to `dat_mem`
- `mem_rdata`  in  DW  combinational read data from `dat_mem`

## Operation
- The block holds two registered states, `ARB_CORE` (core priority) and `ARB_HOST` (host priority), and a starvation counter `wait_cnt` of width `$clog2(MAX_WAIT+1)`.
- Grant is combinational from the state and the current requests:
  - Only `core_req` high: core granted.
  - Only `host_req` high: host granted.
  - Both high: host wins if the state is `ARB_HOST` or `core_halt`=1. Otherwise the core wins.
  - Neither high: no grant.
- Granted side drives `mem_addr` and `mem_wdata`. `mem_we` equals the granted side's `we`. With no grant, `mem_we`=0 and `mem_addr`/`mem_wdata` follow the core.
- `host_ack`=1 exactly when the host is granted. `host_rdata`=`mem_rdata` in that cycle. `core_rdata`=`mem_rdata` always.
- `core_stall`=1 exactly when `core_req`=1 and the host is granted.
- State and counter update at the rising edge:
  - Host granted: `wait_cnt`←0, state←`ARB_CORE`.
  - Host lost a conflict: `wait_cnt`←`wait_cnt`+1. If the new value equals `MAX_WAIT`, state←`ARB_HOST`.
  - `host_req`=0: `wait_cnt`←0 and the state is held. A pending `ARB_HOST` is kept until the host is next granted.
- Host protocol:
  - Request fields are stable while `host_req`=1.
  - After `host_ack`, the host may drop the request or present a new one in the next cycle.
  - Changing request fields before the ack is illegal, and the bench asserts on it.
- The counter saturates at `MAX_WAIT`; it never wraps.

## Timing
- Reset (`reset`=0, asynchronous): state←`ARB_CORE`, `wait_cnt`←0. While reset is asserted, `host_ack`, `core_stall` and `mem_we` are forced to 0. An access in flight when reset hits is dropped, and the host re-issues it.
- Host latency:
  - 0 cycles with no conflict: ack in the cycle the request is presented.
  - Worst case `MAX_WAIT` cycles with the core requesting every cycle: ack in cycle `MAX_WAIT`+1.
- Core loses at most one cycle per `MAX_WAIT`+1 cycles while `core_halt`=0.
- Writes commit at the rising edge ending the grant cycle. A read in the cycle after a write to the same address returns the new data.
- No registered outputs: every output is valid combinationally within the cycle.

## Structure
- Package `dmem_arb_pkg` holds:
  - `typedef enum logic {ARB_CORE, ARB_HOST} arb_state_t`
  - a function computing the counter width from `MAX_WAIT`
- The design is a single module with no sub-modules. The grant logic is one `always_comb` block, and state plus counter are one `always_ff` block sensitive to `posedge clk or negedge reset`.

## Test plan
- Host-only write then read: host writes 0x5A to address 0x10, then reads 0x10. Each request acks in the cycle it is presented, and the read returns `host_rdata`=0x5A; `core_stall` stays 0.
- Continuous conflict with `MAX_WAIT`=4: core requests every cycle and the host requests a read of 0x20 from cycle 0. Expected:
  - `host_ack` rises in cycle 4, and `core_stall`=1 only in cycle 4.
  - The core is granted in cycles 0–3 and 5.
- Halted core: `core_halt`=1, both sides request, and the core writes 0x11 to 0x30 while the host writes 0x22 to 0x30. Expected:
  - The host is granted immediately, `core_stall`=1, and memory 0x30 holds 0x22.
- Request withdrawn: the host loses 2 conflicts, then drops `host_req` for one cycle, then re-requests. `wait_cnt` restarts from 0, so the ack comes 4 conflict cycles later.
- Async reset mid-starvation: assert `reset`=0 between clock edges while `wait_cnt`=3. Expected:
  - `host_ack`, `core_stall` and `mem_we` fall to 0 immediately, before the next clock edge.
  - After release, the state is `ARB_CORE` and the host again needs 4 losses before gaining priority.
